// File: rtl/vpu_dst_port_arbiter.sv
`default_nettype none
// ============================================================================
// vpu_dst_port_arbiter : round-robin, non-preemptive sharer of one SRAM
//                        destination write port among NUM_REQ WB requesters
// Revision: 1.0
// ============================================================================
module vpu_dst_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 256,
  parameter int WID_WIDTH  = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             s_req_i,
  input  logic [NUM_REQ*WID_WIDTH-1:0]   s_wid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_addr_i,
  input  logic [NUM_REQ-1:0]             s_web_i,
  input  logic [NUM_REQ-1:0]             s_wlast_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_wdata_i,
  output logic [NUM_REQ-1:0]             s_ack_o,
  output logic                           m_req_o,
  output logic [WID_WIDTH-1:0]           m_wid_o,
  output logic [ADDR_WIDTH-1:0]          m_addr_o,
  output logic                           m_web_o,
  output logic                           m_wlast_o,
  output logic [DATA_WIDTH-1:0]          m_wdata_o,
  input  logic                           m_ack_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o,
  output logic                           err_timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [WID_WIDTH-1:0]  wid_a   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wid_a[i]   = s_wid_i[i*WID_WIDTH +: WID_WIDTH];
    assign addr_a[i]  = s_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first requester after the last one granted.
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_vld && s_req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Downstream mux; idle values match the reset values of the port.
  always_comb begin
    m_req_o   = 1'b0;
    m_wid_o   = '0;
    m_addr_o  = '0;
    m_web_o   = 1'b1;
    m_wlast_o = 1'b0;
    m_wdata_o = '0;
    s_ack_o   = '0;
    if (state_q == S_GRANT) begin
      m_req_o   = s_req_i[gidx_q];
      m_wid_o   = wid_a[gidx_q];
      m_addr_o  = addr_a[gidx_q];
      m_web_o   = s_web_i[gidx_q];
      m_wlast_o = s_wlast_i[gidx_q];
      m_wdata_o = wdata_a[gidx_q];
      s_ack_o   = grant_q & {NUM_REQ{m_ack_i}};
    end
  end

  logic burst_end;
  assign burst_end = (state_q == S_GRANT) && m_req_o && m_ack_i && m_wlast_o;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          grant_d = C_ONE << pick_idx;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (burst_end) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          rr_ptr_d = gidx_q;
        end else begin
          if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if ((TIMEOUT != 0) && (cnt_d == C_CNT_MAX)) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      gidx_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign grant_o       = grant_q;
  assign busy_o        = (state_q == S_GRANT);
  assign err_timeout_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vpu_dst_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vpu_dst_port_arbiter : directed bench with grant-order scoreboard
// Revision: 1.0
// ============================================================================
module tb_vpu_dst_port_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int WID_WIDTH  = 2;
  localparam int ADDR_WIDTH = 10;
  localparam int TIMEOUT    = 8;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            s_req_i;
  logic [NUM_REQ*WID_WIDTH-1:0]  s_wid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr_i;
  logic [NUM_REQ-1:0]            s_web_i;
  logic [NUM_REQ-1:0]            s_wlast_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata_i;
  logic [NUM_REQ-1:0]            s_ack_o;
  logic                          m_req_o;
  logic [WID_WIDTH-1:0]          m_wid_o;
  logic [ADDR_WIDTH-1:0]         m_addr_o;
  logic                          m_web_o;
  logic                          m_wlast_o;
  logic [DATA_WIDTH-1:0]         m_wdata_o;
  logic                          m_ack_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;
  logic                          err_timeout_o;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  logic [NUM_REQ-1:0] prev_grant = '0;

  always #5 clk = ~clk;

  vpu_dst_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .WID_WIDTH(WID_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_i(s_req_i), .s_wid_i(s_wid_i), .s_addr_i(s_addr_i),
    .s_web_i(s_web_i), .s_wlast_i(s_wlast_i), .s_wdata_i(s_wdata_i),
    .s_ack_o(s_ack_o),
    .m_req_o(m_req_o), .m_wid_o(m_wid_o), .m_addr_o(m_addr_o),
    .m_web_o(m_web_o), .m_wlast_o(m_wlast_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    return 32'(16 + i);
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Scoreboard: each new grant must match the next queued expected index.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] oh;
    if (grant_o != '0 && prev_grant == '0) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 32'(grant_o), 32'd0);
      end else begin
        oh = NUM_REQ'(1) << exp_q.pop_front();
        chk("grant_order", 32'(grant_o), 32'(oh));
      end
    end
    prev_grant <= grant_o;
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      s_wid_i[i*WID_WIDTH +: WID_WIDTH]    = WID_WIDTH'(i);
      s_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(exp_addr(i));
      s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH] = exp_data(i);
    end
    s_web_i   = '0;
    s_wlast_i = '1;
    s_req_i   = '0;
    m_ack_i   = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_m_req", 32'(m_req_o), 32'd0);
    chk("rst_m_web", 32'(m_web_o), 32'd1);
    chk("rst_m_addr", 32'(m_addr_o), 32'd0);
    chk("rst_err", 32'(err_timeout_o), 32'd0);
    #2 rst_n = 1'b1;

    // Single requester 2, ack on second cycle of m_req_o
    exp_q.push_back(2);
    s_req_i = 4'b0100;
    tick;
    chk("t1_grant", 32'(grant_o), 32'h4);
    chk("t1_m_req", 32'(m_req_o), 32'd1);
    chk("t1_m_addr", 32'(m_addr_o), exp_addr(2));
    chk("t1_m_wdata", 32'(m_wdata_o), exp_data(2));
    chk("t1_m_web", 32'(m_web_o), 32'd0);
    chk("t1_ack_none", 32'(s_ack_o), 32'd0);
    tick;
    m_ack_i = 1'b1;
    #1;
    chk("t1_ack_route", 32'(s_ack_o), 32'h4);
    tick;
    s_req_i = '0;
    m_ack_i = 1'b0;
    chk("t1_idle_grant", 32'(grant_o), 32'd0);
    chk("t1_idle_busy", 32'(busy_o), 32'd0);
    chk("t1_idle_web", 32'(m_web_o), 32'd1);
    tick;
    chk("t1_stay_idle", 32'(grant_o), 32'd0);

    // All requesting, single beats, immediate ack: 0,1,2,3,0 with idle gaps
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    foreach (exp_q[i]) chk("t2_queue_clean", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    s_req_i = 4'b1111;
    m_ack_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t2_rr_seq", 32'(grant_o), (i % 2 == 0) ? (32'd1 << ((i / 2) % 4)) : 32'd0);
    end
    s_req_i = '0;
    m_ack_i = 1'b0;

    // Requester 1 four-beat burst while requester 3 waits
    exp_q.push_back(1); exp_q.push_back(3);
    s_wlast_i = 4'b1000;
    s_req_i   = 4'b1010;
    m_ack_i   = 1'b1;
    tick;
    for (int b = 0; b < 4; b++) begin
      s_wlast_i[1] = (b == 3);
      #1;
      chk("t3_grant_held", 32'(grant_o), 32'h2);
      chk("t3_wlast", 32'(m_wlast_o), (b == 3) ? 32'd1 : 32'd0);
      chk("t3_addr", 32'(m_addr_o), exp_addr(1));
      tick;
    end
    s_req_i[1] = 1'b0;
    chk("t3_gap", 32'(grant_o), 32'd0);
    tick;
    chk("t3_next", 32'(grant_o), 32'h8);
    chk("t3_ack3", 32'(s_ack_o), 32'h8);
    chk("t3_wid3", 32'(m_wid_o), 32'd3);
    tick;
    s_req_i = '0;
    m_ack_i = 1'b0;

    // Burst end of 0 coincides with new reqs from 0 and 2: 2 wins
    exp_q.push_back(0); exp_q.push_back(2);
    s_wlast_i = 4'b1111;
    s_req_i   = 4'b0001;
    tick;
    chk("t4_grant0", 32'(grant_o), 32'h1);
    s_req_i = 4'b0101;
    m_ack_i = 1'b1;
    #1;
    chk("t4_ack0", 32'(s_ack_o), 32'h1);
    tick;
    chk("t4_gap", 32'(grant_o), 32'd0);
    tick;
    chk("t4_grant2", 32'(grant_o), 32'h4);
    tick;
    s_req_i = '0;
    m_ack_i = 1'b0;

    // Timeout: requester 0 never acked for TIMEOUT grant cycles
    exp_q.push_back(0);
    s_req_i = 4'b0001;
    tick;
    chk("t5_err_start", 32'(err_timeout_o), 32'd0);
    repeat (TIMEOUT - 1) tick;
    chk("t5_err_before", 32'(err_timeout_o), 32'd0);
    tick;
    chk("t5_err_set", 32'(err_timeout_o), 32'd1);
    chk("t5_still_grant", 32'(grant_o), 32'h1);
    m_ack_i = 1'b1;
    tick;
    s_req_i = '0;
    m_ack_i = 1'b0;
    chk("t5_released", 32'(grant_o), 32'd0);
    chk("t5_sticky", 32'(err_timeout_o), 32'd1);
    tick;
    chk("t5_sticky2", 32'(err_timeout_o), 32'd1);

    // Asynchronous reset in the middle of a burst
    exp_q.push_back(1);
    s_wlast_i = 4'b1101;
    s_req_i   = 4'b0010;
    m_ack_i   = 1'b1;
    tick;
    tick;
    chk("t6_pre_grant", 32'(grant_o), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_m_req", 32'(m_req_o), 32'd0);
    chk("t6_m_web", 32'(m_web_o), 32'd1);
    chk("t6_grant", 32'(grant_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_s_ack", 32'(s_ack_o), 32'd0);
    chk("t6_err_clr", 32'(err_timeout_o), 32'd0);
    s_req_i = '0;
    m_ack_i = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("t6_idle_after", 32'(grant_o), 32'd0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
